// File: rtl/lcd_text_buffer.sv
// Character-stream front end for a 2x16 LCD: maintains a 32-cell text frame from a byte stream.
// Optional feature: define LCD_SCROLL_EN to scroll line 1 up instead of wrapping to line 0.
module lcd_text_buffer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] CODE_CLR   = 8'h0C,
  parameter logic [7:0] CODE_NL    = 8'h0A,
  parameter logic [7:0] CODE_BS    = 8'h08
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic [0:31][7:0] ASCII,
  output logic [4:0]       cursor,
  output logic             busy
);

  // state  | meaning
  // IDLE   | accepting bytes
  // CLEAR  | blanking one cell per cycle, 32 cycles
  // SCROLL | moving line 1 to line 0 one column per cycle, 16 cycles
`ifdef LCD_SCROLL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SCROLL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1} state_t;
`endif

  state_t     state, state_nxt;
  logic [4:0] op_idx;
  logic       take;
  logic       is_print;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign take     = in_valid && in_ready;
  assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          if (in_char == CODE_CLR) state_nxt = CLEAR;
`ifdef LCD_SCROLL_EN
          else if (is_print && cursor == 5'd31) state_nxt = SCROLL;
          else if (in_char == CODE_NL && cursor[4]) state_nxt = SCROLL;
`endif
        end
      end
      CLEAR: if (op_idx == 5'd31) state_nxt = IDLE;
`ifdef LCD_SCROLL_EN
      SCROLL: if (op_idx == 5'd15) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Index restarts from zero whenever the FSM sits in IDLE, so every entry begins at cell 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) op_idx <= 5'd0;
    else       op_idx <= (state == IDLE) ? 5'd0 : op_idx + 5'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ASCII  <= {32{BLANK_CHAR}};
      cursor <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            if (is_print) begin
              ASCII[cursor] <= in_char;
              cursor        <= cursor + 5'd1;
            end else if (in_char == CODE_NL) begin
              cursor <= cursor[4] ? 5'd0 : 5'd16;
            end else if (in_char == CODE_BS) begin
              if (cursor != 5'd0) begin
                cursor                <= cursor - 5'd1;
                ASCII[cursor - 5'd1]  <= BLANK_CHAR;
              end
            end
          end
        end
        CLEAR: begin
          ASCII[op_idx] <= BLANK_CHAR;
          if (op_idx == 5'd31) cursor <= 5'd0;
        end
`ifdef LCD_SCROLL_EN
        SCROLL: begin
          ASCII[{1'b0, op_idx[3:0]}] <= ASCII[{1'b1, op_idx[3:0]}];
          ASCII[{1'b1, op_idx[3:0]}] <= BLANK_CHAR;
          if (op_idx == 5'd15) cursor <= 5'd16;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: directed cases plus random byte stream against a frame model.
module tb_lcd_text_buffer;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CLR   = 8'h0C;
  localparam logic [7:0] NL    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_ready;
  logic [0:31][7:0] ascii_w;
  logic [4:0]       cursor;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] m_frame [32];
  int         m_cur;

  lcd_text_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .ASCII    (ascii_w),
    .cursor   (cursor),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_frame[i] = BLANK;
    m_cur = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < 16; i++) begin
      m_frame[i]      = m_frame[i + 16];
      m_frame[i + 16] = BLANK;
    end
    m_cur = 16;
  endtask

  // Returns the number of cycles the block should stay busy after accepting c.
  task automatic model_byte(input logic [7:0] c, output int busy_exp);
    busy_exp = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_frame[m_cur] = c;
      if (m_cur == 31) begin
`ifdef LCD_SCROLL_EN
        model_scroll();
        busy_exp = 16;
`else
        m_cur = 0;
`endif
      end else begin
        m_cur = m_cur + 1;
      end
    end else if (c == NL) begin
      if (m_cur < 16) m_cur = 16;
      else begin
`ifdef LCD_SCROLL_EN
        model_scroll();
        busy_exp = 16;
`else
        m_cur = 0;
`endif
      end
    end else if (c == BS) begin
      if (m_cur > 0) begin
        m_cur = m_cur - 1;
        m_frame[m_cur] = BLANK;
      end
    end else if (c == CLR) begin
      for (int i = 0; i < 32; i++) m_frame[i] = BLANK;
      m_cur = 0;
      busy_exp = 32;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_cell%0d", tag, i), 32'(ascii_w[i]), 32'(m_frame[i]));
  endtask

  // Sends one byte from an idle negedge and returns at the first negedge with in_ready high again.
  task automatic send(input logic [7:0] c);
    int exp_busy;
    int n;
    model_byte(c, exp_busy);
    @(negedge clk);
    chk("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_char  = 8'($urandom);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      chk("busy_tracks", 32'(busy), 32'd1);
      n++;
      @(negedge clk);
    end
    chk($sformatf("busy_len_%0h", c), 32'(n), 32'(exp_busy));
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return 8'($urandom_range(8'h20, 8'h7E));
    else if (r < 80) return NL;
    else if (r < 90) return BS;
    else if (r < 92) return CLR;
    else if (r < 96) return 8'($urandom_range(0, 8'h1F));
    else             return 8'($urandom_range(8'h7F, 8'hFF));
  endfunction

  initial begin
    int dummy;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    reset = 1'b0;

    // Hello-style write
    send(8'h48);
    send(8'h49);
    compare_all("hi");
    chk("hi_cell0_const", 32'(ascii_w[0]), 32'h48);
    chk("hi_cursor_const", 32'(cursor), 32'd2);

    send(CLR);
    compare_all("clr");

    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(NL);
    compare_all("nl1");
    chk("nl1_cursor_const", 32'(cursor), 32'd16);
    send(NL);
    compare_all("nl2");
    send(CLR);
    send(BS);
    compare_all("bs_at0");

    for (int i = 0; i < 32; i++) send(8'h41);
    send(8'h42);
    compare_all("wrap");

    // Two unsupported bytes back to back with in_valid held
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'h07;
    @(posedge clk);
    #1;
    chk("hold_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_char = 8'hFF;
    @(posedge clk);
    #1;
    chk("hold_ready2", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    model_byte(8'h07, dummy);
    model_byte(8'hFF, dummy);
    @(negedge clk);
    compare_all("ignored");

    // Random stream
    for (int k = 0; k < 300; k++) send(rand_byte());
    compare_all("random");

    // Reset in the 10th cycle of a clear after filling some text
    for (int i = 0; i < 20; i++) send(8'($urandom_range(8'h21, 8'h7E)));
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = CLR;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    chk("mid_clear_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    chk("rst_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all("post_rst");

    send(8'h5A);
    compare_all("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
